// File: rtl/char_motion_ctl.sv
// Character motion controller: per-frame horizontal walk with clamping and a
// ground/rise/fall jump FSM with gravity.
// Latency: outputs update on the clock edge of a frame_tick-high cycle (1 cycle).
// Backpressure: none; without frame_tick all state holds and landed stays low.
// Ports: clk, rst_n (async, active-low), frame_tick, nav_state[2:0]
//        -> xpos[11:0], ypos[11:0], on_the_ground, landed.
module char_motion_ctl #(
  parameter int X_START  = 100,
  parameter int Y_GROUND = 500,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 760,
  parameter int Y_MIN    = 0,
  parameter int STEP_X   = 4,
  parameter int JUMP_V   = 16,
  parameter int GRAVITY  = 2,
  parameter int V_MAX    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [2:0]  nav_state,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        on_the_ground,
  output logic        landed
);

  localparam logic [2:0] NAV_UP    = 3'd1;
  localparam logic [2:0] NAV_LEFT  = 3'd3;
  localparam logic [2:0] NAV_RIGHT = 3'd4;

  // A left step from below this threshold would cross X_MIN, so it clamps.
  localparam logic [12:0] X_LEFT_THR = 13'(X_MIN + STEP_X);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  state_t      state, nx_state;
  logic [7:0]  vel, nx_vel;
  logic [11:0] nx_x, nx_y;
  logic        nx_landed;
  logic [12:0] x13, y13, v13, y_sum;
  logic [8:0]  v_inc;

  always_comb begin
    x13       = {1'b0, xpos};
    y13       = {1'b0, ypos};
    v13       = {5'b0, vel};
    y_sum     = y13 + v13;
    v_inc     = {1'b0, vel} + 9'(GRAVITY);
    nx_x      = xpos;
    nx_y      = ypos;
    nx_vel    = vel;
    nx_state  = state;
    nx_landed = 1'b0;

    // Horizontal motion is independent of the jump state.
    case (nav_state)
      NAV_LEFT: begin
        if (x13 < X_LEFT_THR) nx_x = 12'(X_MIN);
        else                  nx_x = xpos - 12'(STEP_X);
      end
      NAV_RIGHT: begin
        if (x13 + 13'(STEP_X) > 13'(X_MAX)) nx_x = 12'(X_MAX);
        else                                 nx_x = xpos + 12'(STEP_X);
      end
      default: ;
    endcase

    case (state)
      GROUND: begin
        if (nav_state == NAV_UP) begin
          nx_vel   = 8'(JUMP_V);
          nx_state = RISE;
        end else begin
          nx_y   = 12'(Y_GROUND);
          nx_vel = '0;
        end
      end
      RISE: begin
        // Compare as y < Y_MIN + vel so the subtraction can never wrap.
        if (y13 < 13'(Y_MIN) + v13) begin
          nx_y     = 12'(Y_MIN);
          nx_vel   = '0;
          nx_state = FALL;
        end else if (vel > 8'(GRAVITY)) begin
          nx_y   = ypos - {4'b0, vel};
          nx_vel = vel - 8'(GRAVITY);
        end else begin
          nx_y     = ypos - {4'b0, vel};
          nx_vel   = '0;
          nx_state = FALL;
        end
      end
      FALL: begin
        if (y_sum >= 13'(Y_GROUND)) begin
          nx_y      = 12'(Y_GROUND);
          nx_vel    = '0;
          nx_state  = GROUND;
          nx_landed = 1'b1;
        end else begin
          nx_y   = y_sum[11:0];
          nx_vel = (v_inc > 9'(V_MAX)) ? 8'(V_MAX) : v_inc[7:0];
        end
      end
      default: nx_state = GROUND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= GROUND;
      vel           <= '0;
      xpos          <= 12'(X_START);
      ypos          <= 12'(Y_GROUND);
      on_the_ground <= 1'b1;
      landed        <= 1'b0;
    end else begin
      landed <= 1'b0;
      if (frame_tick) begin
        state         <= nx_state;
        vel           <= nx_vel;
        xpos          <= nx_x;
        ypos          <= nx_y;
        on_the_ground <= (nx_state == GROUND);
        landed        <= nx_landed;
      end
    end
  end

endmodule

// File: tb/tb_char_motion_ctl.sv
// Self-checking bench for char_motion_ctl: a reference model pushes expected
// outputs per driven cycle, popped and compared one cycle later.
module tb_char_motion_ctl;

  localparam logic [2:0] STAND = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, frame_tick2;
  logic [2:0]  nav_state, nav2;
  logic [11:0] xpos, ypos, xpos2, ypos2;
  logic        on_the_ground, landed, og2, landed2;

  char_motion_ctl u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .nav_state(nav_state),
    .xpos(xpos), .ypos(ypos), .on_the_ground(on_the_ground), .landed(landed)
  );

  // Second instance starts off the step grid to exercise the left clamp.
  char_motion_ctl #(.X_START(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick2), .nav_state(nav2),
    .xpos(xpos2), .ypos(ypos2), .on_the_ground(og2), .landed(landed2)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int og; int ld;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int mx, my, mv, ms;   // model: x, y, vel, state (0 ground, 1 rise, 2 fall)
  int land_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 100; my = 500; mv = 0; ms = 0;
  endtask

  task automatic model_tick(input logic [2:0] n);
    exp_t e;
    int ld = 0;
    if (n == LEFT)  mx = (mx - 4 < 0) ? 0 : mx - 4;
    if (n == RIGHT) mx = (mx + 4 > 760) ? 760 : mx + 4;
    if (ms == 0) begin
      if (n == UP) begin mv = 16; ms = 1; end
      else begin my = 500; mv = 0; end
    end else if (ms == 1) begin
      if (my - mv < 0) begin my = 0; mv = 0; ms = 2; end
      else begin
        my = my - mv;
        if (mv > 2) mv = mv - 2;
        else begin mv = 0; ms = 2; end
      end
    end else begin
      if (my + mv >= 500) begin my = 500; mv = 0; ms = 0; ld = 1; end
      else begin my = my + mv; mv = (mv + 2 > 16) ? 16 : mv + 2; end
    end
    e.x = mx; e.y = my; e.og = (ms == 0); e.ld = ld;
    q.push_back(e);
  endtask

  task automatic model_hold();
    exp_t e;
    e.x = mx; e.y = my; e.og = (ms == 0); e.ld = 0;
    q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_x"}, int'(xpos), e.x);
      chk({tag, "_y"}, int'(ypos), e.y);
      chk({tag, "_og"}, int'(on_the_ground), e.og);
      chk({tag, "_ld"}, int'(landed), e.ld);
    end
    land_cnt += int'(landed);
  endtask

  task automatic tick(input logic [2:0] n, input string tag);
    @(negedge clk);
    frame_tick = 1'b1;
    nav_state  = n;
    model_tick(n);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    compare_out(tag);
  endtask

  task automatic idle(input logic [2:0] n, input string tag);
    @(negedge clk);
    frame_tick = 1'b0;
    nav_state  = n;
    model_hold();
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, int'(xpos), 100);
    chk({tag, "_y"}, int'(ypos), 500);
    chk({tag, "_og"}, int'(on_the_ground), 1);
    chk({tag, "_ld"}, int'(landed), 0);
  endtask

  initial begin
    rst_n = 1'b1; frame_tick = 1'b0; nav_state = STAND;
    frame_tick2 = 1'b0; nav2 = STAND; land_cnt = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst_hold");
    @(negedge clk) rst_n = 1'b1;

    // Walk right, first tick right after reset release.
    for (int i = 0; i < 10; i++) tick(RIGHT, "walk_r");
    chk("walk_r_end_x", int'(xpos), 140);
    chk("walk_r_end_y", int'(ypos), 500);

    // Walk left into the clamp and push against it.
    for (int i = 0; i < 36; i++) tick(LEFT, "walk_l");
    chk("left_clamp_x", int'(xpos), 0);
    tick(3'd7, "nav7");
    tick(3'd5, "nav5");
    tick(DOWN, "down_gnd");

    // Off-grid left clamp on the second instance.
    chk("x2_start", int'(xpos2), 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      frame_tick2 = 1'b1; nav2 = LEFT;
      @(posedge clk);
      #1 frame_tick2 = 1'b0;
      chk("x2_clamp", int'(xpos2), 0);
    end

    // Single jump: launch, apex at 428, land on tick 18.
    land_cnt = 0;
    tick(UP, "jump1");
    chk("jump1_air", int'(on_the_ground), 0);
    for (int i = 0; i < 8; i++) tick(STAND, "jump1");
    chk("jump1_apex", int'(ypos), 428);
    for (int i = 0; i < 8; i++) tick(STAND, "jump1");
    chk("jump1_prelnd_og", int'(on_the_ground), 0);
    tick(DOWN, "jump1");
    chk("jump1_land_y", int'(ypos), 500);
    chk("jump1_land_og", int'(on_the_ground), 1);
    idle(STAND, "jump1_after");
    chk("jump1_land_cnt", land_cnt, 1);

    // UP held with RIGHT on alternate ticks: exactly one jump.
    land_cnt = 0;
    for (int i = 0; i < 18; i++) tick((i % 2 == 0) ? UP : RIGHT, "alt");
    chk("alt_land_cnt", land_cnt, 1);
    chk("alt_x", int'(xpos), 36);
    chk("alt_og", int'(on_the_ground), 1);

    // Freeze mid-jump for 50 cycles, then resume and land.
    tick(UP, "frz");
    for (int i = 0; i < 3; i++) tick(STAND, "frz");
    for (int i = 0; i < 50; i++) idle((i % 2 == 0) ? UP : RIGHT, "frz_hold");
    chk("frz_y", int'(ypos), 458);
    for (int i = 0; i < 14; i++) tick(STAND, "frz_run");
    chk("frz_og", int'(on_the_ground), 1);

    // Asynchronous reset during the rise abandons the jump.
    tick(UP, "rjmp");
    for (int i = 0; i < 5; i++) tick(STAND, "rjmp");
    chk("rjmp_y440", int'(ypos), 440);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_outputs("arst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(UP, "fresh");
    chk("fresh_og", int'(on_the_ground), 0);
    tick(STAND, "fresh");
    chk("fresh_y", int'(ypos), 484);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/char_motion_ctl.md
CHAR_MOTION_CTL -- requirements
Module: char_motion_ctl

Interface
REQ-001 Parameter X_START, 100: horizontal position after reset.
REQ-002 Parameter Y_GROUND, 500: ground-line vertical position (y grows downward).
REQ-003 Parameter X_MIN, 0 / X_MAX, 760: horizontal clamp limits, inclusive.
REQ-004 Parameter Y_MIN, 0: ceiling limit, inclusive.
REQ-005 Parameter STEP_X, 4: horizontal pixels per frame tick.
REQ-006 Parameter JUMP_V, 16 / GRAVITY, 2 / V_MAX, 16: launch speed, per-tick speed change, and fall-speed cap.
REQ-007 Port clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-008 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 Port frame_tick, input, 1: one-cycle pulse per video frame; motion updates occur only on cycles where it is high.
REQ-010 Port nav_state, input, 3: movement command, encoded 000 STAND, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT.
REQ-011 Port xpos, output, 12: registered character x, unsigned.
REQ-012 Port ypos, output, 12: registered character y, unsigned.
REQ-013 Port on_the_ground, output, 1: registered; high only in state GROUND.
REQ-014 Port landed, output, 1: registered one-cycle pulse on the FALL->GROUND transition.

Function
REQ-015 Internal FSM SHALL have states GROUND, RISE, FALL, plus an 8-bit unsigned vertical speed register vel.
REQ-016 All outputs SHALL update on the clock edge of a frame_tick-high cycle (1-cycle latency); without frame_tick, xpos, ypos, vel and the state SHALL hold, and landed SHALL be 0.
REQ-017 nav_state codes 101-111 SHALL be treated as STAND.
REQ-018 LEFT on a tick, in any FSM state: xpos = max(xpos - STEP_X, X_MIN), computed without unsigned underflow.
REQ-019 RIGHT on a tick, in any FSM state: xpos = min(xpos + STEP_X, X_MAX).
REQ-020 STAND, UP and DOWN SHALL leave xpos unchanged.
REQ-021 GROUND with UP on a tick: vel = JUMP_V, next state RISE, ypos unchanged on that tick.
REQ-022 GROUND with any other command: the FSM stays in GROUND and ypos = Y_GROUND.
REQ-023 RISE on a tick, when vel > GRAVITY: ypos = ypos - vel and vel = vel - GRAVITY; the state stays RISE.
REQ-024 RISE on a tick, when vel <= GRAVITY: ypos = ypos - vel, vel = 0, next state FALL.
REQ-025 RISE: if ypos - vel < Y_MIN, then ypos = Y_MIN, vel = 0, next state FALL, and this rule overrides REQ-023 and REQ-024.
REQ-026 FALL on a tick, when ypos + vel >= Y_GROUND: ypos = Y_GROUND, vel = 0, next state GROUND, and landed = 1 for one cycle.
REQ-027 FALL otherwise: ypos = ypos + vel and vel = min(vel + GRAVITY, V_MAX).
REQ-028 UP while in RISE or FALL SHALL be ignored (no double jump); DOWN SHALL never alter vertical motion.
REQ-029 Horizontal and vertical updates on the same tick SHALL apply together, independently.
REQ-030 Vertical arithmetic SHALL use at least 13-bit intermediates so that compares never wrap.

Reset
REQ-031 While rst_n is 0, the outputs SHALL be: xpos = X_START, ypos = Y_GROUND, on_the_ground = 1, landed = 0; the FSM SHALL be in GROUND with vel = 0.
REQ-032 Reset asserted mid-jump SHALL take effect immediately, without waiting for clk, and SHALL abandon the jump.
REQ-033 The first tick after rst_n releases SHALL be processed normally.

Verification
REQ-034 Reset, then 10 ticks with nav_state = RIGHT -> xpos = 140, ypos = 500, on_the_ground = 1 throughout.
REQ-035 xpos = 2, then 1 tick with LEFT -> xpos = 0; 1 more LEFT tick -> xpos stays 0.
REQ-036 UP for 1 tick, then STAND -> on_the_ground = 0 after the launch tick:
- ypos reaches 428 after 8 further ticks;
- ypos returns to 500 on tick 18, with landed pulsed exactly once and on_the_ground = 1.
REQ-037 UP held for the whole jump, plus RIGHT on alternating ticks -> exactly one jump; xpos advances 4 per RIGHT tick while airborne.
REQ-038 frame_tick held low for 50 cycles mid-jump -> xpos, ypos and state frozen; motion resumes on the next tick.
REQ-039 rst_n pulsed low at ypos = 440 during RISE -> immediately xpos = 100, ypos = 500, on_the_ground = 1; the next UP tick starts a fresh jump.
